wb_stage_p: RTL

- Parametrised writeback stage, sitting between the memory stage and the register-file write port.
- Accepts one retiring instruction per cycle through a valid/ready handshake. A one-entry skid buffer is included, so `in_ready` comes straight from a flop.
- Aligns and extends sub-word load data, and routes the link register for JAL/JALR.
- Runs a halt-drain state machine and keeps a retired-instruction counter.

---
 rtl/wb_stage_p_if.sv | 21 ++
 rtl/wb_stage_p.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_stage_p_if.sv
// Upstream (memory stage -> writeback) valid/ready bus.
interface wb_stage_p_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] IR_in;
  logic [WIDTH-3:0] PC_in;
  logic [WIDTH-1:0] Z_in;
  logic [1:0]       byte_off;

  modport master (
    output in_valid, IR_in, PC_in, Z_in, byte_off,
    input  in_ready
  );

  modport slave (
    input  in_valid, IR_in, PC_in, Z_in, byte_off,
    output in_ready
  );
endinterface

// File: rtl/wb_stage_p.sv
// Writeback stage: load alignment/extension, link routing, output register
// plus one-entry skid buffer, halt-drain FSM and retire counter.
module wb_stage_p #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned LINK_REG     = 31,
  parameter int unsigned SIGN_EXT     = 1,
  parameter int unsigned ZERO_REG_WR  = 0,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wb_stage_p_if.slave             up,
  input  logic                    rf_ready,
  output logic [REG_ADDR_LEN-1:0] Addr,
  output logic [WIDTH-1:0]        Data,
  output logic                    wr_en,
  output logic [1:0]              w_mode,
  output logic                    Halt,
  output logic [CNT_W-1:0]        retired,
  output logic [WIDTH-3:0]        PC_out
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpIType = 6'h01;
  localparam logic [5:0] OpLw    = 6'h02;
  localparam logic [5:0] OpLh    = 6'h03;
  localparam logic [5:0] OpLd    = 6'h04;
  localparam logic [5:0] OpJal   = 6'h05;
  localparam logic [5:0] OpJalr  = 6'h06;
  localparam logic [5:0] OpHalt  = 6'h3F;

  typedef struct packed {
    logic [WIDTH-3:0]        pc;
    logic [REG_ADDR_LEN-1:0] addr;
    logic [WIDTH-1:0]        data;
    logic                    wr;
    logic [1:0]              mode;
    logic                    halt;
  } entry_t;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  entry_t           out_q, out_d, skid_q, skid_d, dec;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0]              opcode;
  logic [REG_ADDR_LEN-1:0] rd;
  logic [WIDTH-1:0]        z_half_sh, z_byte_sh;
  logic [15:0]             half;
  logic [7:0]              byte_v;
  logic                    accept, pop, out_space;
  logic                    unused_ir;

  assign opcode    = up.IR_in[WIDTH-1 -: 6];
  assign rd        = up.IR_in[WIDTH-7 -: REG_ADDR_LEN];
  assign unused_ir = ^up.IR_in[WIDTH-7-REG_ADDR_LEN:0];

  assign z_half_sh = up.Z_in >> {up.byte_off[1], 4'b0000};
  assign z_byte_sh = up.Z_in >> {up.byte_off, 3'b000};
  assign half      = z_half_sh[15:0];
  assign byte_v    = z_byte_sh[7:0];

  assign accept    = up.in_valid & in_ready_q;
  // Non-writing entries leave the output register without waiting on the RF.
  assign pop       = out_valid_q & (~out_q.wr | rf_ready);
  assign out_space = ~out_valid_q | pop;

  // Decode the incoming instruction into a write-port entry.
  always_comb begin
    dec      = '0;
    dec.pc   = up.PC_in;
    dec.addr = rd;
    dec.data = up.Z_in;
    case (opcode)
      OpLw, OpRType, OpIType: dec.wr = 1'b1;
      OpLh: begin
        dec.wr   = 1'b1;
        dec.mode = 2'd1;
        dec.data = {{(WIDTH-16){(SIGN_EXT != 0) & half[15]}}, half};
      end
      OpLd: begin
        dec.wr   = 1'b1;
        dec.mode = 2'd2;
        dec.data = {{(WIDTH-8){(SIGN_EXT != 0) & byte_v[7]}}, byte_v};
      end
      OpJal, OpJalr: begin
        dec.wr   = 1'b1;
        dec.addr = REG_ADDR_LEN'(LINK_REG);
      end
      OpHalt:  dec.halt = 1'b1;
      default: ;
    endcase
    // Writes to x0 are dropped but the instruction still retires.
    if (ZERO_REG_WR == 0 && dec.addr == '0) dec.wr = 1'b0;
  end

  // Next state for output/skid registers, FSM and retire counter.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (pop) cnt_d = cnt_q + CNT_W'(1);
    // in_ready_q implies the skid is empty, so accept and a full skid never coincide.
    if (out_space) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    case (state_q)
      StRun:    if (accept && dec.halt) state_d = StDrain;
      // HALT is the last accepted entry, so its retirement empties the stage.
      StDrain:  if (pop && out_q.halt && !skid_valid_q) state_d = StHalted;
      StHalted: ;
      default:  state_d = StRun;
    endcase
    in_ready_d = ~skid_valid_d & (state_d == StRun);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign up.in_ready = in_ready_q;
  assign Addr        = out_q.addr;
  assign Data        = out_q.data;
  assign w_mode      = out_q.mode;
  assign PC_out      = out_q.pc;
  assign wr_en       = out_valid_q & out_q.wr;
  assign Halt        = (state_q == StHalted);
  assign retired     = cnt_q;

endmodule
